// File: rtl/ina219_power_avg.sv
// ina219_power_avg: periodic power sampling, 2^AVG_LOG2 moving average and double-dabble BCD conversion.
// Optional peak tracker on peak_out is built when INA219_POWER_AVG_PEAK_EN is defined.
module ina219_power_avg #(
  parameter int unsigned SAMPLE_PERIOD = 25_000_000,
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  output logic [15:0] avg_out,
  output logic [19:0] bcd_out,
  output logic        valid,
  output logic        busy,
  output logic [15:0] peak_out
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW = 16 + AVG_LOG2;
  typedef enum logic [2:0] {IDLE, ACCUM, DIVIDE, CONVERT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] cnt;
  logic [15:0] cap_reg, avg_tmp;
  logic [15:0] ring [DEPTH];
  logic [AVG_LOG2-1:0] wptr;
  logic [SW-1:0] sum;
  logic [35:0] dd, dd_adj;
  logic [4:0] iter;
  logic cap;
  assign cap = cnt == SAMPLE_PERIOD - 1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cap ? ACCUM : IDLE;
      ACCUM:   state_nx = DIVIDE;
      DIVIDE:  state_nx = CONVERT;
      CONVERT: state_nx = iter == 5'd1 ? DONE : CONVERT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb busy = state != IDLE;
  // BCD field sits above the binary field; every digit gets its add-3 before the shift
  always_comb begin
    dd_adj = dd;
    for (int i = 0; i < 5; i++)
      dd_adj[16+4*i +: 4] = dd[16+4*i +: 4] >= 4'd5 ? dd[16+4*i +: 4] + 4'd3 : dd[16+4*i +: 4];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      cap_reg <= '0;
      avg_tmp <= '0;
      wptr <= '0;
      sum <= '0;
      dd <= '0;
      iter <= '0;
      avg_out <= '0;
      bcd_out <= '0;
      valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else begin
      cnt <= cap ? '0 : cnt + 32'd1;
      valid <= 1'b0;
      if (cap) cap_reg <= sample_in;
      case (state)
        ACCUM: begin
          sum <= sum + SW'(cap_reg) - SW'(ring[wptr]);
          ring[wptr] <= cap_reg;
          wptr <= wptr + 1'b1;
        end
        DIVIDE: begin
          avg_tmp <= 16'(sum >> AVG_LOG2);
          dd <= {20'd0, 16'(sum >> AVG_LOG2)};
          iter <= 5'd16;
        end
        CONVERT: begin
          dd <= dd_adj << 1;
          iter <= iter - 5'd1;
        end
        DONE: begin
          avg_out <= avg_tmp;
          bcd_out <= dd[35:16];
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`ifdef INA219_POWER_AVG_PEAK_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) peak_out <= '0;
    else if (state == ACCUM && cap_reg > peak_out) peak_out <= cap_reg;
`else
  assign peak_out = 16'h0000;
`endif
endmodule

// File: doc/ina219_power_avg.md
# ina219_power_avg

Post-processing stage directly downstream of the INA219 I2C reader. Periodically samples the reader's 16-bit power register output, keeps a 2^AVG_LOG2-deep moving average, and converts the average to 5-digit packed BCD for the display driver. It emits a one-cycle `valid` strobe per processed sample. One instance sits behind each sensor channel.

## Interface
- `SAMPLE_PERIOD`, 25_000_000: clocks between captures of `sample_in`; legal range 24 to 2^32-1.
- `AVG_LOG2`, 3: log2 of averaging window depth; legal range 1 to 4.

- `clk`  input  1  system clock; the block uses one clock.
- `reset`  input  1  asynchronous, active-low reset.
- `sample_in`  input  16  raw unsigned power reading, taken from the reader's `data_out`.
- `avg_out`  output  16  registered moving average, unsigned.
- `bcd_out`  output  20  packed BCD of `avg_out`, with the ten-thousands digit in [19:16].
- `valid`  output  1  one-cycle pulse when `avg_out` and `bcd_out` update.
- `busy`  output  1  high while the FSM is not in IDLE.
- `peak_out`  output  16  maximum raw sample captured since reset (see Configuration).

## Operation
- **Period counter:** 32-bit counter runs from 0 to SAMPLE_PERIOD-1 and wraps. At count SAMPLE_PERIOD-1, `sample_in` is latched into `cap_reg`. The FSM then goes IDLE -> ACCUM.
- **Ring buffer:** 2^AVG_LOG2 entries × 16 bits, plus a write pointer that wraps modulo depth. Reset clears all entries.
- **Running sum:** width 16+AVG_LOG2 bits. It never overflows.
- **FSM states:**
  - **IDLE:** waits for a capture.
  - **ACCUM:** `sum <= sum + cap_reg - ring[wptr]`, then `ring[wptr] <= cap_reg` and `wptr <= wptr+1`. Next state is DIVIDE.
  - **DIVIDE:** `avg_tmp <= sum >> AVG_LOG2`, truncating. Loads the double-dabble shift register (16 bits binary + 20 bits BCD = 0). Sets the iteration counter to 16. Next state is CONVERT.
  - **CONVERT:** one iteration per clock. Add 3 to each BCD nibble ≥ 5, then shift left 1. After 16 iterations, go to DONE.
  - **DONE:** registers `avg_out <= avg_tmp` and `bcd_out <=` the BCD field, pulses `valid`, and returns to IDLE.
- **Warm-up:** zero-filled entries count toward the average, so the output ramps up over the first 2^AVG_LOG2 samples. No fill counter is kept.
- **Overlapping captures:** a capture during non-IDLE is impossible given SAMPLE_PERIOD ≥ 24. The period counter is free-running and is never stalled by the FSM.
- **Reset mid-operation:** the asynchronous reset returns every register to its reset value immediately. The in-flight sample is discarded, no `valid` pulse is issued, and the counter restarts at 0.

## Timing
- **Reset values:** `avg_out`=0, `bcd_out`=0, `valid`=0, `busy`=0, `peak_out`=0. Period counter, sum, ring and `wptr` are all 0. FSM is in IDLE.
- **First capture:** on the SAMPLE_PERIOD-th rising edge after reset deasserts.
- **Capture edge E0:** `busy` rises after E0.
- **E1:** ACCUM completes.
- **E2:** DIVIDE completes.
- **E3–E18:** the 16 CONVERT iterations.
- **E19:** DONE. `valid`=1 for exactly the cycle after E19; `busy`=0 from E19.
- **Update rate:** outputs change only at the DONE edge and otherwise hold. The processing latency is fixed at 19 clocks from capture to the `valid` cycle.

## Configuration
- Macro `INA219_POWER_AVG_PEAK_EN`.
- **Defined:** `peak_out` updates at the ACCUM edge to max(`peak_out`, `cap_reg`). The comparison is unsigned, and reset is the only way to clear it.
- **Undefined:** no peak logic is synthesized and `peak_out` is tied to 16'h0000. The port remains present in both builds.

## Test plan
All scenarios use SAMPLE_PERIOD=32 and AVG_LOG2=3.
- **Reset:** assert `reset`=0 for 5 clocks, then release. Required: all outputs 0 and the first `valid` pulse exactly 32+19 clocks after release.
- **Ramp-up:** hold `sample_in`=4096. Required: `valid` pulses read avg 512 (`bcd_out`=20'h00512), then 1024, 1536, …, reaching 4096 (20'h04096) on the 8th pulse and holding there.
- **Full scale:** hold `sample_in`=16'hFFFF for 8 captures. Required: `avg_out`=65535 and `bcd_out`=20'h65535 with no wrap. `busy` is high for exactly 19 cycles per capture.
- **Eviction:** after 8 captures of 800, drive 0. Required: successive averages 700, 600, …, 0 (`bcd_out` 20'h00700 … 20'h00000).
- **Mid-conversion reset:** assert `reset` 10 clocks after a capture. Required: outputs 0 at once and no `valid` pulse. After release, the ring starts cleared, so the first average with input 80 is 10.
- **Peak macro:** feed 100, 900, 300. With `INA219_POWER_AVG_PEAK_EN` defined, `peak_out`=900 and holds. Without the macro, `peak_out`=0 throughout.
